// File: rtl/canny_pkg.sv
// canny_pkg: types shared by the window scan controller and the 3x3 window
// buffer.
//   shift_dir_t  : shift strobe direction encoding (the buffer decodes the same)
//   scan_state_t : scan controller FSM states
//   PIX_W        : grayscale pixel width
//   STAGE_N      : pixels entering the window per move
package canny_pkg;

  typedef enum logic [1:0] {
    SHIFT_NONE  = 2'b00,
    SHIFT_RIGHT = 2'b01,
    SHIFT_LEFT  = 2'b10,
    SHIFT_DOWN  = 2'b11
  } shift_dir_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHIFT,
    ST_VALID,
    ST_DONE
  } scan_state_t;

  localparam int PIX_W   = 8;
  localparam int STAGE_N = 3;

endpackage

// File: rtl/scan_addr_gen.sv
// scan_addr_gen: serpentine walk state for the window scan.
// It holds the window centre (row/col), the horizontal sweep direction and the
// prefill column count. It also works out the pixel address of read k for the
// pending move, and the shift direction of that move.
//   clk_i, n_rst_i   : clock, async active-low reset
//   init_i           : frame start; centre goes to (1,1), sweep rightward
//   step_i           : the pending move has been shifted into the buffer
//   k_i              : read index 0..2 within the current fetch
//   addr_o           : row*IMG_WIDTH + col of read k
//   dir_o            : shift direction of the pending move
//   row_o, col_o     : current window centre
//   prefill_more_o   : another prefill column follows the pending one
//   last_o           : the current window is the final one of the frame
module scan_addr_gen import canny_pkg::*; #(
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8,
  parameter int ADDR_W     = 16,
  parameter int COORD_W    = 8
) (
  input  logic               clk_i,
  input  logic               n_rst_i,
  input  logic               init_i,
  input  logic               step_i,
  input  logic [1:0]         k_i,
  output logic [ADDR_W-1:0]  addr_o,
  output shift_dir_t         dir_o,
  output logic [COORD_W-1:0] row_o,
  output logic [COORD_W-1:0] col_o,
  output logic               prefill_more_o,
  output logic               last_o
);

  logic [COORD_W-1:0] row_q, col_q;
  logic [1:0]         pf_q;     // prefill columns shifted so far; 3 = done
  logic               right_q;  // horizontal sweep direction
  logic               prefill, at_edge;
  logic [ADDR_W-1:0]  row_a, col_a, k_a, frow, fcol;

  assign prefill = (pf_q != 2'd3);
  // Edge in the current sweep direction: the next move is a down move
  assign at_edge = right_q ? (col_q == COORD_W'(IMG_WIDTH-2))
                           : (col_q == COORD_W'(1));

  assign row_a = ADDR_W'(row_q);
  assign col_a = ADDR_W'(col_q);
  assign k_a   = ADDR_W'(k_i);

  always_comb begin
    frow  = '0;
    fcol  = '0;
    dir_o = SHIFT_RIGHT;
    if (prefill) begin
      // prefill walks columns 0..2, rows top to bottom
      frow = k_a;
      fcol = ADDR_W'(pf_q);
    end else if (at_edge) begin
      frow  = row_a + ADDR_W'(2);
      fcol  = col_a - ADDR_W'(1) + k_a;
      dir_o = SHIFT_DOWN;
    end else if (right_q) begin
      frow = row_a - ADDR_W'(1) + k_a;
      fcol = col_a + ADDR_W'(2);
    end else begin
      frow  = row_a - ADDR_W'(1) + k_a;
      fcol  = col_a - ADDR_W'(2);
      dir_o = SHIFT_LEFT;
    end
  end

  assign addr_o         = frow * ADDR_W'(IMG_WIDTH) + fcol;
  assign row_o          = row_q;
  assign col_o          = col_q;
  assign prefill_more_o = (pf_q < 2'd2);
  assign last_o         = !prefill && at_edge && (row_q == COORD_W'(IMG_HEIGHT-2));

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      row_q   <= '0;
      col_q   <= '0;
      pf_q    <= '0;
      right_q <= 1'b1;
    end else if (init_i) begin
      row_q   <= COORD_W'(1);
      col_q   <= COORD_W'(1);
      pf_q    <= '0;
      right_q <= 1'b1;
    end else if (step_i) begin
      if (prefill) begin
        pf_q <= pf_q + 2'd1;
      end else if (at_edge) begin
        row_q   <= row_q + COORD_W'(1);
        right_q <= ~right_q;
      end else if (right_q) begin
        col_q <= col_q + COORD_W'(1);
      end else begin
        col_q <= col_q - COORD_W'(1);
      end
    end
  end

endmodule

// File: rtl/window_scan_ctrl.sv
// window_scan_ctrl: drives the 3x3 window buffer over a frame in serpentine
// order. Each move reads three pixels, shifts them into the buffer and then
// flags the new window.
//   clk_i, n_rst_i          : clock, async active-low reset
//   start_i                 : begin a frame (sampled in IDLE only)
//   mem_read_o/mem_addr_o   : pixel read request, held until mem_ready_i
//   mem_rdata_i/mem_ready_i : read data and completion
//   shift_enable_o          : one-cycle shift strobe to the buffer
//   shift_direction_o       : shift_dir_t encoding, NONE outside the strobe
//   buffer_input_o          : staged pixels [0..2] for the entering row/column
//   window_valid_o          : buffer holds a new complete window
//   window_row_o/_col_o     : centre of that window
//   busy_o, done_o          : scan in progress / end-of-frame pulse
module window_scan_ctrl import canny_pkg::*; #(
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8,
  parameter int ADDR_W     = 16,
  parameter int COORD_W    = 8
) (
  input  logic                  clk_i,
  input  logic                  n_rst_i,
  input  logic                  start_i,
  output logic                  mem_read_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  input  logic [PIX_W-1:0]      mem_rdata_i,
  input  logic                  mem_ready_i,
  output logic                  shift_enable_o,
  output logic [1:0]            shift_direction_o,
  output logic [0:2][PIX_W-1:0] buffer_input_o,
  output logic                  window_valid_o,
  output logic [COORD_W-1:0]    window_row_o,
  output logic [COORD_W-1:0]    window_col_o,
  output logic                  busy_o,
  output logic                  done_o
);

  scan_state_t       state_q, state_d;
  logic [1:0]        k_q, k_d;
  logic [PIX_W-1:0]  stage_q [STAGE_N];
  logic              init, step, pf_more, last;
  logic [ADDR_W-1:0] addr;
  shift_dir_t        dir;

  scan_addr_gen #(
    .IMG_WIDTH (IMG_WIDTH),
    .IMG_HEIGHT(IMG_HEIGHT),
    .ADDR_W    (ADDR_W),
    .COORD_W   (COORD_W)
  ) u_addr (
    .clk_i         (clk_i),
    .n_rst_i       (n_rst_i),
    .init_i        (init),
    .step_i        (step),
    .k_i           (k_q),
    .addr_o        (addr),
    .dir_o         (dir),
    .row_o         (window_row_o),
    .col_o         (window_col_o),
    .prefill_more_o(pf_more),
    .last_o        (last)
  );

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // Stage k captures only on a completed read; ready with no request is dropped
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      for (int i = 0; i < STAGE_N; i++) stage_q[i] <= '0;
    end else if (state_q == ST_FETCH && mem_ready_i) begin
      for (int i = 0; i < STAGE_N; i++)
        if (k_q == 2'(i)) stage_q[i] <= mem_rdata_i;
    end
  end

  assign buffer_input_o = {stage_q[0], stage_q[1], stage_q[2]};
  assign mem_addr_o     = mem_read_o ? addr : '0;

  always_comb begin
    state_d           = state_q;
    k_d               = k_q;
    mem_read_o        = 1'b0;
    shift_enable_o    = 1'b0;
    shift_direction_o = SHIFT_NONE;
    window_valid_o    = 1'b0;
    done_o            = 1'b0;
    busy_o            = 1'b1;
    init              = 1'b0;
    step              = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          init    = 1'b1;
          k_d     = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        mem_read_o = 1'b1;
        if (mem_ready_i) begin
          if (k_q == 2'd2) begin
            k_d     = '0;
            state_d = ST_SHIFT;
          end else begin
            k_d = k_q + 2'd1;
          end
        end
      end
      ST_SHIFT: begin
        shift_enable_o    = 1'b1;
        shift_direction_o = dir;
        step              = 1'b1;
        // pf_more reflects the pre-step count, so the third prefill shift
        // falls through to the first window
        state_d = pf_more ? ST_FETCH : ST_VALID;
      end
      ST_VALID: begin
        window_valid_o = 1'b1;
        state_d        = last ? ST_DONE : ST_FETCH;
      end
      ST_DONE: begin
        done_o  = 1'b1;
        busy_o  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_o  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_window_scan_ctrl.sv
// tb_window_scan_ctrl: scoreboard bench. A 4x4 instance is checked read by
// read, shift by shift and window by window against a serpentine model. A 3x3
// and a 5x4 instance cover the smallest frame and a non-square frame.
module tb_window_scan_ctrl;
  import canny_pkg::*;

  logic clk, n_rst;
  int   cyc = 0;
  int   n_cmp = 0, n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- 4x4 instance ----------------
  logic              start, m_read, m_ready, m_sen, m_wv, m_busy, m_done;
  logic [15:0]       m_addr;
  logic [1:0]        m_sdir;
  logic [0:2][7:0]   m_buf;
  logic [7:0]        m_row, m_col;
  int                rdy_dly, wcnt;

  assign m_ready = m_read && (wcnt >= rdy_dly);
  always @(posedge clk or negedge n_rst)
    if (!n_rst) wcnt <= 0;
    else if (m_read && !m_ready) wcnt <= wcnt + 1;
    else wcnt <= 0;

  window_scan_ctrl #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .ADDR_W(16), .COORD_W(8)) dut (
    .clk_i(clk), .n_rst_i(n_rst), .start_i(start),
    .mem_read_o(m_read), .mem_addr_o(m_addr), .mem_rdata_i(m_addr[7:0]), .mem_ready_i(m_ready),
    .shift_enable_o(m_sen), .shift_direction_o(m_sdir), .buffer_input_o(m_buf),
    .window_valid_o(m_wv), .window_row_o(m_row), .window_col_o(m_col),
    .busy_o(m_busy), .done_o(m_done));

  int           eaddr[$];
  logic [25:0]  eshift[$];
  logic [15:0]  evalid[$];
  int           exp_gap, lat_chk, ndone = 0;
  int           t0, last_v, nsh;
  logic         busy_p, stall_p;
  logic [15:0]  addr_p;

  // Serpentine reference: pushes every read address, shift and window centre
  task automatic push_scan(int w, int h);
    int a[3];
    int r, c;
    bit right;
    logic [1:0] d;
    for (int col = 0; col < 3; col++) begin
      for (int k = 0; k < 3; k++) begin a[k] = k * w + col; eaddr.push_back(a[k]); end
      eshift.push_back({SHIFT_RIGHT, 8'(a[0]), 8'(a[1]), 8'(a[2])});
    end
    evalid.push_back({8'd1, 8'd1});
    r = 1; c = 1; right = 1'b1;
    while (1) begin
      if (right ? (c == w - 2) : (c == 1)) begin
        if (r == h - 2) break;
        for (int k = 0; k < 3; k++) a[k] = (r + 2) * w + (c - 1 + k);
        d = SHIFT_DOWN; r++; right = !right;
      end else begin
        c = right ? c + 1 : c - 1;
        for (int k = 0; k < 3; k++) a[k] = (r - 1 + k) * w + (right ? c + 1 : c - 1);
        d = right ? SHIFT_RIGHT : SHIFT_LEFT;
      end
      for (int k = 0; k < 3; k++) eaddr.push_back(a[k]);
      eshift.push_back({d, 8'(a[0]), 8'(a[1]), 8'(a[2])});
      evalid.push_back({8'(r), 8'(c)});
    end
  endtask

  always @(negedge clk) begin
    if (!n_rst) begin
      eaddr.delete(); eshift.delete(); evalid.delete();
      last_v = -1; nsh = 0; stall_p = 0; busy_p = 0;
    end else begin
      if (m_busy && !busy_p) t0 = cyc;
      busy_p = m_busy;
      if (stall_p && m_read) chk("addr_stable", m_addr, addr_p);
      stall_p = m_read && !m_ready;
      addr_p  = m_addr;
      if (m_read && m_ready) begin
        chk("addr_avail", 64'(eaddr.size() != 0), 1);
        if (eaddr.size() != 0) chk("addr", m_addr, eaddr.pop_front());
      end
      if (m_sen) begin
        nsh++;
        chk("shift_avail", 64'(eshift.size() != 0), 1);
        if (eshift.size() != 0) chk("shift_dir_buf", {m_sdir, m_buf}, eshift.pop_front());
        if (nsh == 1 && lat_chk != 0) chk("first_shift_lat", cyc - t0, 3);
      end
      if (m_wv) begin
        chk("valid_avail", 64'(evalid.size() != 0), 1);
        if (evalid.size() != 0) chk("centre", {m_row, m_col}, evalid.pop_front());
        if (last_v >= 0) chk("valid_gap", cyc - last_v, exp_gap);
        else if (lat_chk != 0) chk("first_valid_lat", cyc - t0, 12);
        last_v = cyc;
      end
      if (m_done) begin
        chk("done_lat", cyc - last_v, 1);
        chk("busy_at_done", m_busy, 0);
        chk("leftover", eaddr.size() + eshift.size() + evalid.size(), 0);
        ndone++; last_v = -1; nsh = 0;
      end
    end
  end

  // ---------------- 3x3 instance, ready tied high ----------------
  logic        start3, rd3, sen3, wv3, busy3, done3;
  logic [15:0] addr3;
  logic [1:0]  sdir3;
  logic [0:2][7:0] buf3;
  logic [7:0]  row3, col3;
  int          exp3[9] = '{0, 3, 6, 1, 4, 7, 2, 5, 8};
  int          i3, ns3, t03, nd3 = 0;
  logic        busy3_p;

  window_scan_ctrl #(.IMG_WIDTH(3), .IMG_HEIGHT(3), .ADDR_W(16), .COORD_W(8)) dut3 (
    .clk_i(clk), .n_rst_i(n_rst), .start_i(start3),
    .mem_read_o(rd3), .mem_addr_o(addr3), .mem_rdata_i(addr3[7:0]), .mem_ready_i(1'b1),
    .shift_enable_o(sen3), .shift_direction_o(sdir3), .buffer_input_o(buf3),
    .window_valid_o(wv3), .window_row_o(row3), .window_col_o(col3),
    .busy_o(busy3), .done_o(done3));

  always @(negedge clk) begin
    if (!n_rst) begin
      i3 = 0; ns3 = 0; busy3_p = 0;
    end else begin
      if (busy3 && !busy3_p) t03 = cyc;
      busy3_p = busy3;
      if (rd3) begin
        if (i3 < 9) chk("s3_addr", addr3, exp3[i3]);
        i3++;
      end
      if (sen3) begin ns3++; chk("s3_dir", sdir3, SHIFT_RIGHT); end
      if (wv3) begin
        chk("s3_valid_lat", cyc - t03, 12);
        chk("s3_centre", {row3, col3}, 16'h0101);
      end
      if (done3) begin
        chk("s3_done_lat", cyc - t03, 13);
        chk("s3_shifts", ns3, 3);
        chk("s3_reads", i3, 9);
        nd3++; i3 = 0; ns3 = 0;
      end
    end
  end

  // ---------------- 5x4 instance, ready tied high ----------------
  logic        start5, rd5, sen5, wv5, busy5, done5;
  logic [15:0] addr5;
  logic [1:0]  sdir5;
  logic [0:2][7:0] buf5;
  logic [7:0]  row5, col5, lr5, lc5;
  int          nv5, nd5 = 0;

  window_scan_ctrl #(.IMG_WIDTH(5), .IMG_HEIGHT(4), .ADDR_W(16), .COORD_W(8)) dut5 (
    .clk_i(clk), .n_rst_i(n_rst), .start_i(start5),
    .mem_read_o(rd5), .mem_addr_o(addr5), .mem_rdata_i(addr5[7:0]), .mem_ready_i(1'b1),
    .shift_enable_o(sen5), .shift_direction_o(sdir5), .buffer_input_o(buf5),
    .window_valid_o(wv5), .window_row_o(row5), .window_col_o(col5),
    .busy_o(busy5), .done_o(done5));

  always @(negedge clk) begin
    if (!n_rst) nv5 = 0;
    else begin
      if (wv5) begin nv5++; lr5 = row5; lc5 = col5; end
      if (done5) begin
        chk("s5_windows", nv5, 6);
        chk("s5_last_centre", {lr5, lc5}, {8'd2, 8'd1});
        nd5++; nv5 = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_all(int tgt, int tgt3, int tgt5);
    int i = 0;
    while ((ndone < tgt || nd3 < tgt3 || nd5 < tgt5) && i < 3000) begin
      @(negedge clk); i++;
    end
    chk("scan_done", ndone, tgt);
    chk("scan3_done", nd3, tgt3);
    chk("scan5_done", nd5, tgt5);
  endtask

  task automatic pulse_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  initial begin
    int i;
    n_rst = 1'b0; start = 1'b0; start3 = 1'b0; start5 = 1'b0;
    rdy_dly = 0; exp_gap = 5; lat_chk = 1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {m_read, m_addr, m_sen, m_sdir, m_buf, m_wv, m_row, m_col, m_busy, m_done}, 0);
    @(posedge clk); #1 n_rst = 1'b1;
    @(negedge clk);

    // all three frames with ready tied high
    push_scan(4, 4);
    start = 1'b1; start3 = 1'b1; start5 = 1'b1;
    @(negedge clk);
    start = 1'b0; start3 = 1'b0; start5 = 1'b0;
    wait_all(1, 1, 1);

    // every read stalled by 3 cycles
    rdy_dly = 3; exp_gap = 14; lat_chk = 0;
    push_scan(4, 4);
    pulse_start();
    wait_all(2, 1, 1);

    // start re-pulsed mid-scan must not disturb the sequence
    rdy_dly = 0; exp_gap = 5; lat_chk = 1;
    push_scan(4, 4);
    pulse_start();
    repeat (20) @(negedge clk);
    pulse_start();
    wait_all(3, 1, 1);

    // reset during the second FETCH, then a clean rescan
    push_scan(4, 4);
    pulse_start();
    i = 0;
    while (!m_sen && i < 200) begin @(negedge clk); i++; end
    chk("first_shift_seen", m_sen, 1);
    @(posedge clk); #2;
    chk("in_second_fetch", m_read, 1);
    n_rst = 1'b0;
    #1;
    chk("abort_outputs", {m_read, m_addr, m_sen, m_sdir, m_buf, m_wv, m_row, m_col, m_busy, m_done}, 0);
    @(negedge clk);
    @(posedge clk); #1 n_rst = 1'b1;
    @(negedge clk);
    push_scan(4, 4);
    pulse_start();
    wait_all(4, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/window_scan_ctrl.md
# window_scan_ctrl

Upstream controller for the 3x3 window buffer. It walks a grayscale image held in pixel memory in serpentine order and reads, one pixel at a time, the three pixels that enter the window on each move. It drives the buffer's shift_enable, shift_direction and buffer_input, and pulses window_valid once the buffer holds each new complete 3x3 window. The filter stages downstream consume the window on that pulse.

## Interface
- IMG_WIDTH, 8: image width in pixels; must be ≥3.
- IMG_HEIGHT, 8: image height in pixels; must be ≥3.
- ADDR_W, 16: pixel memory address width.
- COORD_W, 8: width of the row/column coordinate outputs.
- clk  in  1  system clock. Single clock domain; all logic on the rising edge.
- n_rst  in  1  reset, asynchronous, active-low.
- start  in  1  begin a frame scan; sampled only in IDLE.
- mem_read  out  1  read request; held high until mem_ready.
- mem_addr  out  ADDR_W  address = row*IMG_WIDTH + col; stable while mem_read is high.
- mem_rdata  in  8  read data; valid in the cycle mem_ready is high.
- mem_ready  in  1  read completes this cycle.
- shift_enable  out  1  one-cycle shift strobe to the window buffer.
- shift_direction  out  2  00 none, 01 right, 10 left, 11 down.
- buffer_input  out  8 x [0:2]  staged pixels for the entering row or column.
- window_valid  out  1  one-cycle pulse: the buffer holds a new complete window.
- window_row, window_col  out  COORD_W each  centre coordinates of the current window.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse after the last window.

## Operation
- States:
  - IDLE → FETCH when start is high.
  - FETCH issues 3 sequential reads, index k = 0..2, and stores mem_rdata into stage[k] on mem_ready. After k = 2 completes → SHIFT.
  - SHIFT: shift_enable = 1 for one cycle with the current direction. Then → FETCH while prefilling, otherwise → VALID.
  - VALID: window_valid = 1. Then → FETCH if windows remain, otherwise → DONE.
  - DONE: done = 1. Then → IDLE.
- Prefill:
  - Three right shifts load columns 0, 1, 2 of rows 0..2; reads are taken in row order within each column.
  - The first window centre is (1,1).
- Moving right:
  - Fetch column c+2 (c is the centre column), rows r-1..r+1; direction 01.
  - stage[k] holds row r-1+k.
- At the right edge (c = IMG_WIDTH-2):
  - Move down: fetch row r+2, columns c-1..c+1; direction 11.
  - stage[k] holds column c-1+k.
  - After the down move, the horizontal direction flips.
- Moving left:
  - Fetch column c-2, rows r-1..r+1; direction 10.
  - At the left edge (c = 1), move down and flip to rightward.
- The scan ends when the current row pass completes at r = IMG_HEIGHT-2. Total windows = (IMG_WIDTH-2)*(IMG_HEIGHT-2).
- buffer_input holds the stage registers continuously. Stage values are stable in the SHIFT cycle.
- Boundary and error handling:
  - start is ignored in any state other than IDLE.
  - mem_ready arriving while mem_read is low is ignored.
  - Assertion of n_rst mid-scan aborts the scan. The window buffer shares n_rst, so it clears at the same time.
- Reset values: all outputs 0; stage registers 0; state IDLE; direction register rightward.

## Timing
- With mem_ready tied high, each read takes 1 cycle. Cycles per move: 3 (FETCH) + 1 (SHIFT) + 1 (VALID) = 5.
- Latency from start accepted at edge N:
  - First mem_read in cycle N+1.
  - First SHIFT in cycle N+4.
  - First window_valid in cycle N+13.
  - Later window_valid pulses every 5 cycles.
- window_valid rises the cycle after shift_enable, once the buffer register has updated. window_row and window_col are valid in that cycle.
- A mem_ready stall of S cycles on any read delays every later event by S cycles.
- done occurs exactly 1 cycle after the last window_valid; busy falls in the same cycle done is high.

## Structure
- Shared package canny_pkg contains:
  - shift_dir_t enum: SHIFT_NONE = 2'b00, SHIFT_RIGHT = 2'b01, SHIFT_LEFT = 2'b10, SHIFT_DOWN = 2'b11. The window buffer must use the same encoding.
  - scan_state_t enum for the FSM states.
- Sub-module scan_addr_gen holds the centre row/column counters, the serpentine direction, and the next-fetch address calculation. The controller FSM instantiates it.

## Test plan
- 3x3 image, mem_ready tied high:
  - Addresses must be 0,3,6,1,4,7,2,5,8.
  - Exactly 3 right shifts, then one window_valid at (1,1) in cycle N+13.
  - done pulses in cycle N+14.
- 4x4 image, memory holding the value equal to its address:
  - Expected order: prefill 0,4,8 / 1,5,9 / 2,6,10; valid (1,1). Then 3,7,11, right; valid (1,2). Then 13,14,15, down; valid (2,2). Then 4,8,12, left; valid (2,1). Then done.
  - buffer_input must carry {13,14,15} during the down shift.
- mem_ready delayed by 3 cycles on every read:
  - mem_addr must stay stable while mem_read is high.
  - window_valid spacing must be 14 cycles.
- start pulsed again mid-scan: ignored, and the address sequence is unchanged.
- n_rst asserted during the second FETCH:
  - All outputs are 0 immediately.
  - A subsequent start rescans from address 0.
- 5x4 image: window_valid count must be 6 and the last centre must be (2,1).
